// File: rtl/ibex_pkg.sv
// Shared types and defaults for the IF/ID dummy-instruction stage.
package ibex_pkg;

  localparam int unsigned DummyCntWDefault = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        is_dummy;
    logic        err;
  } id_entry_t;

endpackage

// File: rtl/ibex_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ibex_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_if_dummy_stage.sv
// IF/ID register muxing dummy-generator inserts with real fetches; a dummy
// takes an ID slot while the real fetch stays pending in the prefetch buffer.
module ibex_if_dummy_stage
  import ibex_pkg::*;
#(
  parameter bit          DummyInstrEn = 1'b1,
  parameter int unsigned CntW         = DummyCntWDefault
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [31:0]     fetch_addr_i,
  input  logic            fetch_err_i,
  output logic            fetch_ready_o,
  input  logic            insert_dummy_instr_i,
  input  logic [31:0]     dummy_instr_data_i,
  input  logic            id_in_ready_i,
  input  logic            halt_if_i,
  input  logic            flush_i,
  input  logic            cnt_clr_i,
  output logic            instr_valid_id_o,
  output logic [31:0]     instr_rdata_id_o,
  output logic [31:0]     instr_addr_id_o,
  output logic            instr_is_dummy_o,
  output logic            instr_fetch_err_o,
  output logic [CntW-1:0] dummy_cnt_o
);

  logic      ins, adv, load;
  logic      valid_q;
  id_entry_t id_q, id_d;
  logic [CntW-1:0] cnt;

  assign ins  = DummyInstrEn & insert_dummy_instr_i;
  assign adv  = id_in_ready_i & ~halt_if_i & ~flush_i;
  assign load = adv & (fetch_valid_i | ins);

  // A dummy never consumes the real fetch; it keeps that fetch's PC instead.
  assign fetch_ready_o = adv & fetch_valid_i & ~ins;

  always_comb begin
    id_d = id_q;
    if (ins) begin
      id_d.rdata    = dummy_instr_data_i;
      id_d.addr     = fetch_addr_i;
      id_d.is_dummy = 1'b1;
      id_d.err      = 1'b0;
    end else begin
      id_d.rdata    = fetch_rdata_i;
      id_d.addr     = fetch_addr_i;
      id_d.is_dummy = 1'b0;
      id_d.err      = fetch_err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (id_in_ready_i) begin
      // halt or nothing to load becomes a bubble; data regs keep old contents
      valid_q <= load;
      if (load) id_q <= id_d;
    end
  end

  ibex_sat_counter #(.W(CntW)) u_dummy_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (load & ins),
    .cnt_o (cnt)
  );

  assign dummy_cnt_o       = cnt & {CntW{DummyInstrEn}};
  assign instr_valid_id_o  = valid_q;
  assign instr_rdata_id_o  = id_q.rdata;
  assign instr_addr_id_o   = id_q.addr;
  assign instr_is_dummy_o  = id_q.is_dummy;
  assign instr_fetch_err_o = id_q.err;

endmodule
